core_seq: RTL and testbench

Multi-cycle control sequencer for the single-issue core. Drives instruction fetch and latches the instruction for instr_decode. Steps the fetch/decode/execute/memory/writeback phases, using the decode flags to choose the path. Owns the PC and the write port of regs (w_en/waddr/wdata). Sits between the memory interfaces and the instr_decode/ALU/regs datapath.

---
 rtl/core_pkg.sv | 22 ++
 rtl/core_wait_timer.sv | 41 ++++
 rtl/core_seq.sv | 209 ++++++++++++++++++++
 tb/tb_core_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: datapath width, reset PC default
// and the externally visible FSM state encoding.
package core_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  // Instruction addresses must be word aligned.
  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/core_wait_timer.sv
// Memory-request watchdog: counts un-acked cycles and flags the cycle in which
// the MAX_WAIT-th consecutive un-acked cycle is being spent.
module core_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Saturating count, clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/core_seq.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer owning the PC and the
// register-file write port. Optional perf counters under CORE_SEQ_PERF_EN.
module core_seq
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            is_reg,
  input  logic            is_alu,
  input  logic [4:0]      dest,
  input  logic [XLEN-1:0] alu_result,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_w_en,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            trap
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     retired_cnt
`endif
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic            rf_w_en_q, rf_w_en_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic            tmr_clr_s;
  logic            tmr_en_s;
  logic            tmr_expired_s;

  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] next_pc_s;
  logic [XLEN-1:0] wb_data_s;
  logic            any_flag_s;
  logic            mem_op_s;
  logic            redirect_s;
  logic            wr_ok_s;

  core_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (tmr_clr_s),
    .en_i      (tmr_en_s),
    .expired_o (tmr_expired_s)
  );

  assign pc_plus4_s = pc_q + 32'd4;
  assign any_flag_s = is_load | is_store | is_branch | is_jump | is_reg | is_alu;
  assign mem_op_s   = is_load | is_store;
  assign redirect_s = is_jump | (is_branch & branch_taken);
  assign next_pc_s  = redirect_s ? branch_target : pc_plus4_s;
  assign wr_ok_s    = (is_load | is_jump | is_alu) && (dest != 5'd0);
  assign wb_data_s  = is_load ? ld_data_q : (is_jump ? pc_plus4_s : alu_result);

  // Next-state logic; the wait timer only runs while a request is outstanding.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ld_data_d  = ld_data_q;
    rf_w_en_d  = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    tmr_clr_s  = 1'b1;
    tmr_en_s   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        tmr_clr_s = 1'b0;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end else if (tmr_expired_s) begin
          state_d = ST_TRAP;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!any_flag_s) begin
          state_d = ST_TRAP;
        end else if (mem_op_s) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        tmr_clr_s = 1'b0;
        if (dmem_ack) begin
          if (is_load) begin
            ld_data_d = dmem_rdata;
          end else begin
            ld_data_d = ld_data_q;
          end
          state_d = ST_WB;
        end else if (tmr_expired_s) begin
          state_d = ST_TRAP;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_WB: begin
        // A misaligned target retires nothing: no write, PC left as is.
        if (misaligned(next_pc_s)) begin
          state_d = ST_TRAP;
        end else begin
          pc_d       = next_pc_s;
          rf_w_en_d  = wr_ok_s;
          rf_waddr_d = dest;
          rf_wdata_d = wb_data_s;
          state_d    = ST_FETCH;
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      ld_data_q  <= 32'd0;
      rf_w_en_q  <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ld_data_q  <= ld_data_d;
      rf_w_en_q  <= rf_w_en_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Gating with reset keeps the fetch request low while reset is held.
  assign imem_req  = (state_q == ST_FETCH) && reset;
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == ST_MEM);
  assign dmem_we   = (state_q == ST_MEM) && is_store;
  assign instr     = instr_q;
  assign rf_w_en   = rf_w_en_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pc        = pc_q;
  assign state     = state_q;
  assign trap      = (state_q == ST_TRAP);

`ifdef CORE_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] retired_cnt_q;

  // Free-running cycle counter (frozen in TRAP) and retirement counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= 32'd0;
      retired_cnt_q <= 32'd0;
    end else begin
      if (state_q != ST_TRAP) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if ((state_q == ST_WB) && (state_d == ST_FETCH)) begin
        retired_cnt_q <= retired_cnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Randomized bench for core_seq: a per-instruction timeline model predicts every
// cycle's outputs, and a single negedge process compares the DUT against it.
module tb_core_seq;

  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0, dmem_rdata = 32'd0;
  logic        is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0;
  logic        is_jump = 1'b0, is_reg = 1'b0, is_alu = 1'b0;
  logic [4:0]  dest = 5'd0;
  logic [31:0] alu_result = 32'd0, branch_target = 32'd0;
  logic        branch_taken = 1'b0;

  logic        imem_req, dmem_req, dmem_we, rf_w_en, trap;
  logic [31:0] imem_addr, instr, rf_wdata, pc;
  logic [4:0]  rf_waddr;
  logic [2:0]  state;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  always #5 clk = ~clk;

  core_seq #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .is_reg(is_reg), .is_alu(is_alu),
    .dest(dest), .alu_result(alu_result), .branch_taken(branch_taken), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rf_w_en(rf_w_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc(pc), .state(state), .trap(trap)
`ifdef CORE_SEQ_PERF_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  typedef struct {
    logic [2:0]  st;
    logic        ireq, dreq, dwe, wen, trp;
    logic [4:0]  waddr;
    logic [31:0] wdata, pc, instr, cc, rc;
  } exp_t;

  typedef struct {
    int          fd, md, abort;
    logic [31:0] rdata, alu, tgt, ldata;
    logic        ld, st, br, jp, rg, al, taken;
    logic [4:0]  dest;
  } ins_t;

  int          ntests = 0, nfail = 0, dreq_cnt = 0;
  exp_t        exp_r;
  bit          exp_v = 1'b0;
  logic [31:0] pc_m, instr_m, cc_m, rc_m, wp_data;
  logic        wp_en;
  logic [4:0]  wp_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    ntests++;
    if (act !== ex) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, ex, $time);
    end
  endtask

  // The one comparison point against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dmem_req === 1'b1) dreq_cnt++;
    if (exp_v) begin
      chk("state", 32'(state), 32'(exp_r.st));
      chk("pc", pc, exp_r.pc);
      chk("imem_addr", imem_addr, exp_r.pc);
      chk("imem_req", 32'(imem_req), 32'(exp_r.ireq));
      chk("dmem_req", 32'(dmem_req), 32'(exp_r.dreq));
      if (exp_r.dreq) chk("dmem_we", 32'(dmem_we), 32'(exp_r.dwe));
      chk("trap", 32'(trap), 32'(exp_r.trp));
      chk("instr", instr, exp_r.instr);
      chk("rf_w_en", 32'(rf_w_en), 32'(exp_r.wen));
      if (exp_r.wen) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(exp_r.waddr));
        chk("rf_wdata", rf_wdata, exp_r.wdata);
      end
`ifdef CORE_SEQ_PERF_EN
      chk("cycle_cnt", cycle_cnt, exp_r.cc);
      chk("retired_cnt", retired_cnt, exp_r.rc);
`endif
    end
  end

  function automatic exp_t mk(input logic [2:0] st);
    exp_t e;
    e.st = st; e.ireq = (st == 3'd0); e.dreq = 1'b0; e.dwe = 1'b0;
    e.wen = wp_en; e.waddr = wp_addr; e.wdata = wp_data;
    e.pc = pc_m; e.trp = (st == 3'd7); e.instr = instr_m; e.cc = cc_m; e.rc = rc_m;
    return e;
  endfunction

  // One expected cycle: publish it, let the clock edge pass.
  task automatic push(input exp_t e);
    exp_r = e; exp_v = 1'b1;
    @(posedge clk); #1;
    wp_en = 1'b0;
    if (e.st != 3'd7) cc_m = cc_m + 32'd1;
  endtask

  task automatic trap_tail();
    for (int i = 0; i < 5; i++) push(mk(3'd7));
  endtask

  task automatic do_reset();
    exp_v = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_rf_w_en", 32'(rf_w_en), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
`ifdef CORE_SEQ_PERF_EN
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_retired_cnt", retired_cnt, 32'd0);
`endif
    pc_m = 32'd0; instr_m = 32'd0; cc_m = 32'd0; rc_m = 32'd0;
    wp_en = 1'b0; wp_addr = 5'd0; wp_data = 32'd0; dreq_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_imem_req", 32'(imem_req), 32'd1);
  endtask

  function automatic ins_t blank();
    ins_t t;
    t.fd = 0; t.md = 0; t.abort = -1;
    t.rdata = 32'h0000_0013; t.alu = 32'd0; t.tgt = 32'd0; t.ldata = 32'd0;
    t.ld = 1'b0; t.st = 1'b0; t.br = 1'b0; t.jp = 1'b0; t.rg = 1'b0; t.al = 1'b0;
    t.taken = 1'b0; t.dest = 5'd0;
    return t;
  endfunction

  // Drive one instruction and predict every cycle it takes; stop=1 on trap/abort.
  task automatic run_instr(input ins_t t, output bit stop);
    exp_t        e;
    logic [31:0] sel;
    int          fc, mc;
    stop = 1'b0;
    is_load = t.ld; is_store = t.st; is_branch = t.br; is_jump = t.jp;
    is_reg = t.rg; is_alu = t.al; dest = t.dest; alu_result = t.alu;
    branch_taken = t.taken; branch_target = t.tgt; dmem_rdata = t.ldata; imem_rdata = t.rdata;
    fc = (t.fd < MAXW) ? t.fd + 1 : MAXW;
    for (int c = 0; c < fc; c++) begin
      imem_ack = (c == t.fd);
      push(mk(3'd0));
    end
    imem_ack = 1'b0;
    if (t.fd >= MAXW) begin trap_tail(); stop = 1'b1; return; end
    instr_m = t.rdata;
    push(mk(3'd1));
    push(mk(3'd2));
    if (!(t.ld | t.st | t.br | t.jp | t.rg | t.al)) begin trap_tail(); stop = 1'b1; return; end
    if (t.ld | t.st) begin
      mc = (t.md < MAXW) ? t.md + 1 : MAXW;
      for (int c = 0; c < mc; c++) begin
        if (c == t.abort) begin
          chk("abort_dmem_req_live", 32'(dmem_req), 32'd1);
          stop = 1'b1;
          return;
        end
        dmem_ack = (c == t.md);
        e = mk(3'd3); e.dreq = 1'b1; e.dwe = t.st;
        push(e);
      end
      dmem_ack = 1'b0;
      if (t.md >= MAXW) begin trap_tail(); stop = 1'b1; return; end
    end
    push(mk(3'd4));
    sel = (t.jp | (t.br & t.taken)) ? t.tgt : pc_m + 32'd4;
    if (sel[1:0] != 2'b00) begin trap_tail(); stop = 1'b1; return; end
    if ((t.ld | t.jp | t.al) && t.dest != 5'd0) begin
      wp_en = 1'b1; wp_addr = t.dest;
      wp_data = t.ld ? t.ldata : (t.jp ? pc_m + 32'd4 : t.alu);
    end
    pc_m = sel;
    rc_m = rc_m + 32'd1;
  endtask

  function automatic ins_t gen();
    ins_t t;
    int   k;
    t = blank();
    t.fd = int'($urandom_range(0, 3)); t.md = int'($urandom_range(0, 3));
    t.rdata = $urandom; t.alu = $urandom; t.ldata = $urandom;
    t.taken = 1'($urandom_range(0, 1));
    t.dest = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 7) == 0) t.dest = 5'd0;
    t.tgt = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 19) == 0) t.tgt[1:0] = 2'($urandom_range(1, 3));
    k = int'($urandom_range(0, 99));
    if (k < 3)       begin end
    else if (k < 30) begin t.al = 1'b1; t.rg = 1'($urandom_range(0, 1)); end
    else if (k < 45) t.ld = 1'b1;
    else if (k < 55) t.st = 1'b1;
    else if (k < 75) t.br = 1'b1;
    else if (k < 90) t.jp = 1'b1;
    else             t.rg = 1'b1;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t t;
    bit   stop;
    #2;
    do_reset();

    // ALU with a 2-cycle late fetch ack.
    t = blank(); t.fd = 2; t.al = 1'b1; t.dest = 5'd5; t.alu = 32'd42;
    run_instr(t, stop);
    chk("alu_pc", pc, 32'd4);
    chk("alu_wen", 32'(rf_w_en), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata, 32'd42);
    t = blank(); t.al = 1'b1; t.dest = 5'd1; t.alu = 32'd7;
    run_instr(t, stop);
    // jal at pc=8, then jalr to x0.
    t = blank(); t.jp = 1'b1; t.dest = 5'd3; t.tgt = 32'd2008;
    run_instr(t, stop);
    chk("jal_wen", 32'(rf_w_en), 32'd1);
    chk("jal_waddr", 32'(rf_waddr), 32'd3);
    chk("jal_wdata", rf_wdata, 32'd12);
    chk("jal_pc", pc, 32'd2008);
    t = blank(); t.jp = 1'b1; t.dest = 5'd0; t.tgt = 32'd3000;
    run_instr(t, stop);
    chk("jalr_x0_wen", 32'(rf_w_en), 32'd0);
    chk("jalr_pc", pc, 32'd3000);
    // Branches: taken, not taken, misaligned target.
    t = blank(); t.br = 1'b1; t.taken = 1'b1; t.tgt = 32'd2000; t.dest = 5'd9;
    run_instr(t, stop);
    chk("beq_t_pc", pc, 32'd2000);
    chk("beq_t_wen", 32'(rf_w_en), 32'd0);
    t.taken = 1'b0;
    run_instr(t, stop);
    chk("beq_nt_pc", pc, 32'd2004);
    t.taken = 1'b1; t.tgt = 32'd2002;
    run_instr(t, stop);
    chk("mis_trap", 32'(trap), 32'd1);
    chk("mis_pc", pc, 32'd2004);
    do_reset();

    // Load that is never acked.
    t = blank(); t.ld = 1'b1; t.dest = 5'd4; t.md = 1000;
    run_instr(t, stop);
    chk("to_trap", 32'(trap), 32'd1);
    chk("to_dmem_req", 32'(dmem_req), 32'd0);
    chk("to_mem_cycles", 32'(dreq_cnt), 32'd16);
    do_reset();

    // Reset while a load is waiting in MEM.
    t = blank(); t.al = 1'b1; t.dest = 5'd2; t.alu = 32'h55;
    run_instr(t, stop);
    t = blank(); t.ld = 1'b1; t.dest = 5'd6; t.md = 5; t.abort = 2;
    run_instr(t, stop);
    do_reset();

    // Fetch that is never acked.
    t = blank(); t.fd = 1000;
    run_instr(t, stop);
    chk("fto_trap", 32'(trap), 32'd1);
    chk("fto_imem_req", 32'(imem_req), 32'd0);
    do_reset();

`ifdef CORE_SEQ_PERF_EN
    for (int i = 0; i < 3; i++) begin
      t = blank(); t.al = 1'b1; t.dest = 5'(i + 1); t.alu = 32'(i);
      run_instr(t, stop);
    end
    chk("perf_retired", retired_cnt, 32'd3);
    chk("perf_cycles", cycle_cnt, 32'd12);
    do_reset();
`endif

    for (int n = 0; n < 400; n++) begin
      t = gen();
      run_instr(t, stop);
      if (stop) do_reset();
    end

    exp_v = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
